// File: rtl/inst_mem_arbiter_pkg.sv
// Shared bus widths, types and helpers for the instruction-memory arbiter.
// InstAddrBus / InstBus / StallCntBus / ZeroWord live here as typed equivalents.
package inst_mem_arbiter_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int STALL_CNT_W = 16;
  localparam int RUN_CNT_W   = 4;

  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [INST_W-1:0]      inst_bus_t;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_bus_t;
  typedef logic [RUN_CNT_W-1:0]   run_cnt_t;

  localparam inst_bus_t ZERO_WORD = '0;

  // Who drives the memory port in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  function automatic stall_cnt_bus_t stall_cnt_inc(input stall_cnt_bus_t cnt);
    return (cnt == '1) ? cnt : cnt + stall_cnt_bus_t'(1);
  endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// Bundle of the CPU fetch port, debug/loader port and memory port around the arbiter.
// The arbiter takes the slave view; the surrounding SOPC (or a bench) takes the master view.
interface inst_mem_arbiter_if;
  import inst_mem_arbiter_pkg::*;

  // CPU fetch side
  logic           cpu_ce_i;
  inst_addr_bus_t cpu_addr_i;
  inst_bus_t      cpu_inst_o;
  logic           cpu_stall_o;

  // Debug / loader side
  logic           dbg_req_i;
  logic           dbg_we_i;
  inst_addr_bus_t dbg_addr_i;
  inst_bus_t      dbg_wdata_i;
  logic           dbg_gnt_o;
  inst_bus_t      dbg_rdata_o;
  logic           dbg_rvalid_o;

  // Memory side
  logic           mem_ce_o;
  logic           mem_we_o;
  inst_addr_bus_t mem_addr_o;
  inst_bus_t      mem_wdata_o;
  inst_bus_t      mem_rdata_i;

  stall_cnt_bus_t stall_cnt_o;

  modport slave (
    input  cpu_ce_i, cpu_addr_i,
    output cpu_inst_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rdata_o, dbg_rvalid_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output stall_cnt_o
  );

  modport master (
    output cpu_ce_i, cpu_addr_i,
    input  cpu_inst_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rdata_o, dbg_rvalid_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  stall_cnt_o
  );

endinterface

// File: rtl/inst_mem_arbiter.sv
// Shares one instruction memory between the OpenMIPS fetch port and a debug/loader port.
// Debug wins by default; a run counter hands the CPU one cycle after MAX_DBG_RUN contended debug grants.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int MAX_DBG_RUN = 4
) (
  input  logic               clk,
  input  logic               rst,
  inst_mem_arbiter_if.slave  bus
);

  localparam run_cnt_t RUN_LIMIT = run_cnt_t'(MAX_DBG_RUN);

  run_cnt_t       run_cnt;
  stall_cnt_bus_t stall_cnt;
  inst_bus_t      dbg_rdata;
  logic           dbg_rvalid;

  owner_e         owner;
  logic           mem_ce;
  logic           mem_we;
  inst_addr_bus_t mem_addr;
  inst_bus_t      mem_wdata;
  inst_bus_t      cpu_inst;
  logic           cpu_stall;
  logic           dbg_gnt;
  logic           dbg_rd_gnt;

  // Grant decision: the CPU only wins a contended cycle once the debug run is exhausted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    owner = OWN_NONE;
    if (!rst) begin
      if (bus.cpu_ce_i && (!bus.dbg_req_i || run_cnt >= RUN_LIMIT)) begin
        owner = OWN_CPU;
      end else if (bus.dbg_req_i) begin
        owner = OWN_DBG;
      end
    end
  end

  // Memory mux and requester-facing outputs; reset forces everything inactive through owner.
  always_comb begin
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = ZERO_WORD;
    cpu_inst   = ZERO_WORD;
    dbg_gnt    = 1'b0;
    unique case (owner)
      OWN_CPU: begin
        mem_ce   = 1'b1;
        mem_addr = bus.cpu_addr_i;
        cpu_inst = bus.mem_rdata_i;
      end
      OWN_DBG: begin
        mem_ce    = 1'b1;
        mem_we    = bus.dbg_we_i;
        mem_addr  = bus.dbg_addr_i;
        mem_wdata = bus.dbg_wdata_i;
        dbg_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_stall  = !rst && bus.cpu_ce_i && (owner != OWN_CPU);
  assign dbg_rd_gnt = dbg_gnt && !bus.dbg_we_i;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      run_cnt    <= '0;
      stall_cnt  <= '0;
      dbg_rdata  <= ZERO_WORD;
      dbg_rvalid <= 1'b0;
    end else begin
      // The run only lengthens while the CPU is actually waiting on it.
      run_cnt <= (dbg_gnt && bus.cpu_ce_i) ? run_cnt + run_cnt_t'(1) : '0;
      if (cpu_stall) begin
        stall_cnt <= stall_cnt_inc(stall_cnt);
      end
      dbg_rvalid <= dbg_rd_gnt;
      if (dbg_rd_gnt) begin
        dbg_rdata <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.mem_ce_o     = mem_ce;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.cpu_inst_o   = cpu_inst;
  assign bus.cpu_stall_o  = cpu_stall;
  assign bus.dbg_gnt_o    = dbg_gnt;
  assign bus.dbg_rdata_o  = dbg_rdata;
  assign bus.dbg_rvalid_o = dbg_rvalid;
  assign bus.stall_cnt_o  = stall_cnt;

endmodule
